// File: rtl/fifo_burst_serializer.sv
// fifo_burst_serializer
//   Pops a burst of len words from a first-word-fall-through FIFO read port and
//   sends each word MSB-first as Width/OutWidth chunks on a valid/ready stream.
//   Pulses done for one cycle when the whole burst has been accepted.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          burst request and length in words (sampled in IDLE)
//   abort               synchronous cancel, priority over start
//   busy, done          burst in progress / one-cycle completion pulse
//   fifo_r              FIFO pop strobe (combinational, only when fifo_rok=1)
//   fifo_rd, fifo_rok   FIFO head word / FIFO non-empty
//   out_valid, out_data, out_last, out_ready   narrow output stream
module fifo_burst_serializer #(
   parameter int unsigned Width    = 12,
   parameter int unsigned OutWidth = 4,
   parameter int unsigned LenWidth = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LenWidth-1:0] len,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                fifo_r,
   input  logic [Width-1:0]    fifo_rd,
   input  logic                fifo_rok,
   output logic                out_valid,
   output logic [OutWidth-1:0] out_data,
   output logic                out_last,
   input  logic                out_ready
);

   localparam int unsigned Chunks = Width / OutWidth;
   localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [Width-1:0]    r_shreg;
   logic [CntW-1:0]     r_cnt;
   logic [LenWidth-1:0] r_rem;

   logic w_hs;
   logic w_word_end;
   logic w_last_word;
   logic w_pop;

   // Handshake and end-of-word decode
   assign w_hs        = (r_state == S_SHIFT) && out_ready;
   assign w_word_end  = w_hs && (r_cnt == '0);
   assign w_last_word = (r_rem == LenWidth'(1));

   // Pop either to fill from FETCH or to reload back-to-back at the end of a
   // non-final word; abort suppresses any pop in its cycle
   assign w_pop = !abort && fifo_rok &&
                  ((r_state == S_FETCH) || (w_word_end && !w_last_word));

   assign fifo_r    = w_pop;
   assign busy      = (r_state == S_FETCH) || (r_state == S_SHIFT);
   assign done      = (r_state == S_DONE);
   assign out_valid = (r_state == S_SHIFT);
   assign out_data  = (r_state == S_SHIFT) ? r_shreg[Width-1 -: OutWidth] : '0;
   assign out_last  = (r_state == S_SHIFT) && (r_cnt == '0) && w_last_word;

   // Burst control FSM with word shift register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
      end else if (abort) begin
         // captured word is dropped, nothing is returned to the FIFO
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     r_rem   <= len;
                     r_state <= S_FETCH;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_FETCH: begin
               if (fifo_rok) begin
                  r_shreg <= fifo_rd;
                  r_cnt   <= CntW'(Chunks - 1);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_hs) begin
                  if (r_cnt != '0) begin
                     r_shreg <= r_shreg << OutWidth;
                     r_cnt   <= r_cnt - CntW'(1);
                  end else begin
                     r_rem <= r_rem - LenWidth'(1);
                     if (w_last_word) begin
                        r_state <= S_DONE;
                     end else if (fifo_rok) begin
                        r_shreg <= fifo_rd;
                        r_cnt   <= CntW'(Chunks - 1);
                     end else begin
                        r_state <= S_FETCH;
                     end
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_burst_serializer.sv
// tb_fifo_burst_serializer
//   Directed bench for fifo_burst_serializer (Width=12, OutWidth=4) with a
//   small FWFT FIFO model and a negedge stream monitor.
module tb_fifo_burst_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] len;
   logic        abort;
   logic        busy;
   logic        done;
   logic        fifo_r;
   logic [11:0] fifo_rd;
   logic        fifo_rok;
   logic        out_valid;
   logic [3:0]  out_data;
   logic        out_last;
   logic        out_ready;

   int checks   = 0;
   int failures = 0;

   fifo_burst_serializer #(.Width(12), .OutWidth(4), .LenWidth(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .fifo_r    (fifo_r),
      .fifo_rd   (fifo_rd),
      .fifo_rok  (fifo_rok),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // FWFT FIFO model: pushed by the stimulus, popped on clk when fifo_r
   logic [11:0] mem [0:63];
   int wp = 0;
   int rp = 0;
   assign fifo_rok = (wp != rp);
   assign fifo_rd  = mem[rp[5:0]];
   always @(posedge clk) if (fifo_r) rp <= rp + 1;

   // Stream monitor sampled on the falling edge
   int        cyc = 0;
   int        pop_cnt = 0;
   int        rok_viol = 0;
   int        stall_viol = 0;
   int        busy_cnt = 0;
   int        done_cnt = 0;
   int        done_cyc = 0;
   int        cap_n = 0;
   logic [3:0] cap_data [0:127];
   logic       cap_last [0:127];
   int         cap_cyc  [0:127];
   logic       prev_stall = 1'b0;
   logic       prev_abort = 1'b0;
   logic [3:0] prev_data  = '0;
   logic       prev_last  = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (fifo_r) begin
         pop_cnt++;
         if (!fifo_rok) rok_viol++;
      end
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_stall && !prev_abort) begin
            if (!out_valid || out_data !== prev_data || out_last !== prev_last) stall_viol++;
         end
         if (out_valid && out_ready && cap_n < 128) begin
            cap_data[cap_n] = out_data;
            cap_last[cap_n] = out_last;
            cap_cyc[cap_n]  = cyc;
            cap_n++;
         end
         prev_stall = out_valid && !out_ready;
         prev_abort = abort;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] w);
      mem[wp[5:0]] = w;
      wp++;
   endtask

   task automatic do_start(input logic [15:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      len   = '0;
   endtask

   task automatic wait_done(input int base, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (done_cnt > base) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0; out_ready = 1'b1;
      push(12'h999);
      tick(); tick();
      checks++;
      if ({busy, done, fifo_r, out_valid, out_last, out_data} !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0", {busy, done, fifo_r, out_valid, out_last, out_data});
      end
      checks++;
      if (pop_cnt !== 0) begin
         failures++;
         $display("FAIL reset_no_pop got=%0d want=0", pop_cnt);
      end
      rst_n = 1'b1;
      tick();
      wp = rp;
   endtask

   task automatic test_basic();
      logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
      int cb = cap_n, pb = pop_cnt, db = done_cnt;
      bit ok;
      push(12'hABC); push(12'h123);
      out_ready = 1'b1;
      do_start(16'd2);
      wait_done(db, 50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done want=done"); end
      checks++;
      if (cap_n - cb !== 6) begin failures++; $display("FAIL basic_count got=%0d want=6", cap_n - cb); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp[i] || cap_last[cb+i] !== (i == 5) || cap_cyc[cb+i] !== cap_cyc[cb] + i) begin
            failures++;
            $display("FAIL basic_chunk%0d got=%h/%b/+%0d want=%h/%b/+%0d", i, cap_data[cb+i], cap_last[cb+i],
                     cap_cyc[cb+i] - cap_cyc[cb], exp[i], (i == 5), i);
         end
      end
      checks++;
      if (pop_cnt - pb !== 2) begin failures++; $display("FAIL basic_pops got=%0d want=2", pop_cnt - pb); end
      checks++;
      if (done_cnt - db !== 1 || done_cyc !== cap_cyc[cb+5] + 1) begin
         failures++;
         $display("FAIL basic_done got=%0d@+%0d want=1@+1", done_cnt - db, done_cyc - cap_cyc[cb+5]);
      end
   endtask

   task automatic test_stall();
      logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
      logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int cb = cap_n, db = done_cnt, sb = stall_viol;
      bit ok = 1'b0;
      push(12'hABC); push(12'h123);
      do_start(16'd2);
      for (int i = 0; i < 100; i++) begin
         out_ready = pat[i % 6];
         tick();
         if (done_cnt > db) begin ok = 1'b1; break; end
      end
      out_ready = 1'b1;
      tick(); tick();
      checks++;
      if (!ok) begin failures++; $display("FAIL stall_timeout got=no_done want=done"); end
      checks++;
      if (cap_n - cb !== 6) begin failures++; $display("FAIL stall_count got=%0d want=6", cap_n - cb); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp[i] || cap_last[cb+i] !== (i == 5)) begin
            failures++;
            $display("FAIL stall_chunk%0d got=%h/%b want=%h/%b", i, cap_data[cb+i], cap_last[cb+i], exp[i], (i == 5));
         end
      end
      checks++;
      if (stall_viol - sb !== 0) begin failures++; $display("FAIL stall_hold got=%0d want=0", stall_viol - sb); end
      checks++;
      if (done_cnt - db !== 1) begin failures++; $display("FAIL stall_done got=%0d want=1", done_cnt - db); end
   endtask

   task automatic test_gap();
      logic [3:0] exp [9] = '{4'h5, 4'hA, 4'h5, 4'h6, 4'hB, 4'h6, 4'h7, 4'hC, 4'h7};
      int cb = cap_n, pb = pop_cnt, db = done_cnt;
      bit ok;
      push(12'h5A5);
      out_ready = 1'b1;
      do_start(16'd3);
      repeat (5) tick();
      checks++;
      if (out_valid !== 1'b0 || fifo_r !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL gap_stall got=v%b r%b b%b want=v0 r0 b1", out_valid, fifo_r, busy);
      end
      checks++;
      if (cap_n - cb !== 3) begin failures++; $display("FAIL gap_first_word got=%0d want=3", cap_n - cb); end
      push(12'h6B6); push(12'h7C7);
      wait_done(db, 50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL gap_timeout got=no_done want=done"); end
      checks++;
      if (cap_n - cb !== 9) begin failures++; $display("FAIL gap_count got=%0d want=9", cap_n - cb); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp[i] || cap_last[cb+i] !== (i == 8)) begin
            failures++;
            $display("FAIL gap_chunk%0d got=%h/%b want=%h/%b", i, cap_data[cb+i], cap_last[cb+i], exp[i], (i == 8));
         end
      end
      checks++;
      if (pop_cnt - pb !== 3) begin failures++; $display("FAIL gap_pops got=%0d want=3", pop_cnt - pb); end
   endtask

   task automatic test_zero_len();
      int pb = pop_cnt, bb = busy_cnt, db = done_cnt;
      push(12'h111);
      do_start(16'd0);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_done_high got=%b want=1", done); end
      tick();
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL zero_done_low got=%b want=0", done); end
      tick(); tick();
      checks++;
      if (busy_cnt - bb !== 0 || pop_cnt - pb !== 0 || done_cnt - db !== 1) begin
         failures++;
         $display("FAIL zero_side got=busy%0d pop%0d done%0d want=0 0 1", busy_cnt - bb, pop_cnt - pb, done_cnt - db);
      end
      wp = rp;
   endtask

   task automatic test_abort();
      logic [3:0] exp1 [3] = '{4'h1, 4'h2, 4'h3};
      logic [3:0] exp2 [3] = '{4'h7, 4'h8, 4'h9};
      int cb = cap_n, pb = pop_cnt, db = done_cnt, p0;
      bit ok;
      push(12'hABC); push(12'h123); push(12'h456);
      out_ready = 1'b1;
      do_start(16'd3);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cap_n - cb >= 2) break;
      end
      out_ready = 1'b0;
      abort = 1'b1;
      #1;
      checks++;
      if (fifo_r !== 1'b0) begin failures++; $display("FAIL abort_pop_gate got=%b want=0", fifo_r); end
      tick();
      abort = 1'b0;
      out_ready = 1'b1;
      checks++;
      if ({busy, done, fifo_r, out_valid, out_last, out_data} !== 9'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%b want=0", {busy, done, fifo_r, out_valid, out_last, out_data});
      end
      repeat (3) tick();
      checks++;
      if (pop_cnt - pb !== 1 || done_cnt - db !== 0 || cap_n - cb !== 2) begin
         failures++;
         $display("FAIL abort_after got=pop%0d done%0d cap%0d want=1 0 2", pop_cnt - pb, done_cnt - db, cap_n - cb);
      end
      cb = cap_n; db = done_cnt;
      do_start(16'd1);
      wait_done(db, 50, ok);
      checks++;
      if (!ok || cap_n - cb !== 3 || pop_cnt - pb !== 2) begin
         failures++;
         $display("FAIL abort_restart got=ok%b cap%0d pop%0d want=1 3 2", ok, cap_n - cb, pop_cnt - pb);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp1[i] || cap_last[cb+i] !== (i == 2)) begin
            failures++;
            $display("FAIL abort_chunk%0d got=%h/%b want=%h/%b", i, cap_data[cb+i], cap_last[cb+i], exp1[i], (i == 2));
         end
      end
      // asynchronous reset in the middle of a burst of 0x456, 0x789
      push(12'h789);
      cb = cap_n; db = done_cnt;
      do_start(16'd2);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (cap_n - cb >= 1) break;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, fifo_r, out_valid, out_last, out_data} !== 9'd0) begin
         failures++;
         $display("FAIL rst_mid_outputs got=%b want=0", {busy, done, fifo_r, out_valid, out_last, out_data});
      end
      p0 = pop_cnt;
      repeat (3) tick();
      checks++;
      if (pop_cnt !== p0 || done_cnt !== db) begin
         failures++;
         $display("FAIL rst_mid_quiet got=pop%0d done%0d want=%0d %0d", pop_cnt, done_cnt, p0, db);
      end
      rst_n = 1'b1;
      tick();
      cb = cap_n; db = done_cnt;
      do_start(16'd1);
      wait_done(db, 50, ok);
      checks++;
      if (!ok || cap_n - cb !== 3) begin failures++; $display("FAIL rst_restart got=ok%b cap%0d want=1 3", ok, cap_n - cb); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp2[i] || cap_last[cb+i] !== (i == 2)) begin
            failures++;
            $display("FAIL rst_chunk%0d got=%h/%b want=%h/%b", i, cap_data[cb+i], cap_last[cb+i], exp2[i], (i == 2));
         end
      end
      wp = rp;
   endtask

   task automatic test_restart_ignored();
      logic [3:0] exp [6] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2};
      int cb = cap_n, pb = pop_cnt, db = done_cnt;
      bit ok;
      push(12'h111); push(12'h222); push(12'h333); push(12'h444);
      out_ready = 1'b1;
      do_start(16'd2);
      tick(); tick();
      do_start(16'd4);
      wait_done(db, 50, ok);
      repeat (3) tick();
      checks++;
      if (!ok || cap_n - cb !== 6 || pop_cnt - pb !== 2 || done_cnt - db !== 1) begin
         failures++;
         $display("FAIL restart_len got=ok%b cap%0d pop%0d done%0d want=1 6 2 1", ok, cap_n - cb, pop_cnt - pb, done_cnt - db);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (cap_data[cb+i] !== exp[i] || cap_last[cb+i] !== (i == 5)) begin
            failures++;
            $display("FAIL restart_chunk%0d got=%h/%b want=%h/%b", i, cap_data[cb+i], cap_last[cb+i], exp[i], (i == 5));
         end
      end
      wp = rp;
   endtask

   task automatic test_protocol();
      checks++;
      if (rok_viol !== 0) begin failures++; $display("FAIL pop_when_empty got=%0d want=0", rok_viol); end
      checks++;
      if (stall_viol !== 0) begin failures++; $display("FAIL hold_under_stall got=%0d want=0", stall_viol); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_gap();
      test_zero_len();
      test_abort();
      test_restart_ignored();
      test_protocol();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
